// File: rtl/pushbutton_debouncer_pkg.sv
// Shared types for the push-button debouncer: the per-clock counter action
// and the helper that picks it from the idle/full conditions.
package pushbutton_debouncer_pkg;

    typedef enum logic [1:0] {
        ACT_IDLE   = 2'd0,
        ACT_COUNT  = 2'd1,
        ACT_TOGGLE = 2'd2
    } cnt_action_e;

    // A mismatch must persist until the counter is full before the state flips.
    function automatic cnt_action_e decode_action(input logic idle, input logic cnt_full);
        if (idle) begin
            return ACT_IDLE;
        end else if (cnt_full) begin
            return ACT_TOGGLE;
        end else begin
            return ACT_COUNT;
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic sync_1;

    // NOTE: sequential state uses non-blocking assignments so both flops sample
    // their inputs from the same edge; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_1 <= 1'b0;
            q      <= 1'b0;
        end else begin
            sync_1 <= d;
            q      <= sync_1;
        end
    end

endmodule

// File: rtl/pushbutton_debouncer.sv
// Push-button debouncer: synchronizes the raw pin, accepts a level change only
// after 2^WIDTH stable clocks, and emits one-clock press/release strobes.
module pushbutton_debouncer
    import pushbutton_debouncer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic PushButton,
    output logic PB_state,
    output logic PB_down,
    output logic PB_up
);

    localparam logic [WIDTH-1:0] CNT_FULL = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic              sync_2;
    logic              idle;
    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  cnt_next;
    logic              state_next;
    logic              down_next;
    logic              up_next;
    cnt_action_e       action;

    sync_2ff u_sync (
        .clk (clk),
        .clr (clr),
        .d   (PushButton),
        .q   (sync_2)
    );

    assign idle   = (sync_2 == PB_state);
    assign action = decode_action(idle, cnt == CNT_FULL);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        cnt_next   = '0;
        state_next = PB_state;
        down_next  = 1'b0;
        up_next    = 1'b0;
        case (action)
            ACT_COUNT: begin
                cnt_next = cnt + CNT_ONE;
            end
            ACT_TOGGLE: begin
                state_next = ~PB_state;
                down_next  = ~PB_state;
                up_next    = PB_state;
            end
            default: begin
            end
        endcase
    end

    // NOTE: all state including the counter is cleared by the async reset, so
    // a count in progress is discarded and no strobe can leak out of reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt      <= '0;
            PB_state <= 1'b0;
            PB_down  <= 1'b0;
            PB_up    <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            PB_state <= state_next;
            PB_down  <= down_next;
            PB_up    <= up_next;
        end
    end

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Directed self-checking bench for pushbutton_debouncer with WIDTH=8.
module tb_pushbutton_debouncer;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic clr;
    logic PushButton;
    logic PB_state;
    logic PB_down;
    logic PB_up;

    int tests_run    = 0;
    int tests_failed = 0;

    int   downs   = 0;
    int   ups     = 0;
    int   overlap = 0;
    int   wide    = 0;
    logic prev_down = 1'b0;
    logic prev_up   = 1'b0;

    pushbutton_debouncer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clr        (clr),
        .PushButton (PushButton),
        .PB_state   (PB_state),
        .PB_down    (PB_down),
        .PB_up      (PB_up)
    );

    always #10 clk = ~clk;

    // Strobe monitor, sampled mid-cycle so stimulus tasks at negedge see fresh counts.
    always @(posedge clk) begin
        #5;
        if (PB_down) downs++;
        if (PB_up) ups++;
        if (PB_down && PB_up) overlap++;
        if ((PB_down && prev_down) || (PB_up && prev_up)) wide++;
        prev_down = PB_down;
        prev_up   = PB_up;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_track(input int n, inout int peak);
        repeat (n) begin
            @(negedge clk);
            if (int'(dut.cnt) > peak) peak = int'(dut.cnt);
        end
    endtask

    task automatic test_reset;
        clr = 1'b1;
        PushButton = 1'b0;
        #2 clr = 1'b0;
        PushButton = 1'b1;
        wait_clk(3);
        tests_run++;
        if ({PB_state, PB_down, PB_up} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_outputs: state/down/up=%b expected 000", {PB_state, PB_down, PB_up});
        end
        tests_run++;
        if (dut.cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_cnt: cnt=%0d expected 0", dut.cnt);
        end
        tests_run++;
        if ({dut.u_sync.sync_1, dut.sync_2} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_sync: sync_1/sync_2=%b expected 00", {dut.u_sync.sync_1, dut.sync_2});
        end
        PushButton = 1'b0;
        clr = 1'b1;
        wait_clk(2);
    endtask

    task automatic test_press_latency;
        int base_down = downs;
        int base_up   = ups;
        PushButton = 1'b1;
        wait_clk(257);
        tests_run++;
        if (PB_state !== 1'b0 || downs != base_down) begin
            tests_failed++;
            $display("FAIL press_clock257: state=%b downs=%0d expected 0 and 0", PB_state, downs - base_down);
        end
        wait_clk(1);
        tests_run++;
        if (PB_state !== 1'b1 || PB_down !== 1'b1) begin
            tests_failed++;
            $display("FAIL press_clock258: state=%b down=%b expected 1 1", PB_state, PB_down);
        end
        wait_clk(1);
        tests_run++;
        if (PB_down !== 1'b0 || downs - base_down != 1 || ups != base_up) begin
            tests_failed++;
            $display("FAIL press_strobe: down=%b downs=%0d ups=%0d expected 0 1 0",
                     PB_down, downs - base_down, ups - base_up);
        end
    endtask

    task automatic test_glitch_low;
        int base_down = downs;
        int base_up   = ups;
        int peak      = 0;
        for (int i = 0; i < 10; i++) begin
            PushButton = 1'b0;
            run_track(50, peak);
            PushButton = 1'b1;
            run_track(300, peak);
        end
        tests_run++;
        if (PB_state !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_low_state: state=%b expected 1", PB_state);
        end
        tests_run++;
        if (downs != base_down || ups != base_up) begin
            tests_failed++;
            $display("FAIL glitch_low_strobes: downs=%0d ups=%0d expected 0 0", downs - base_down, ups - base_up);
        end
        tests_run++;
        if (peak != 50) begin
            tests_failed++;
            $display("FAIL glitch_low_peak: peak cnt=%0d expected 50", peak);
        end
    endtask

    task automatic test_short_pulses;
        int base_down = downs;
        int base_up   = ups;
        PushButton = 1'b0;
        wait_clk(258);
        tests_run++;
        if (PB_state !== 1'b0 || PB_up !== 1'b1 || ups - base_up != 1) begin
            tests_failed++;
            $display("FAIL release_accept: state=%b up=%b ups=%0d expected 0 1 1", PB_state, PB_up, ups - base_up);
        end
        wait_clk(5);
        base_down = downs;
        base_up   = ups;
        PushButton = 1'b1;
        wait_clk(12);
        PushButton = 1'b0;
        wait_clk(300);
        tests_run++;
        if (PB_state !== 1'b0 || downs != base_down || ups != base_up) begin
            tests_failed++;
            $display("FAIL short_high_pulse: state=%b downs=%0d ups=%0d expected 0 0 0",
                     PB_state, downs - base_down, ups - base_up);
        end
        PushButton = 1'b1;
        wait_clk(257);
        tests_run++;
        if (PB_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_press_257: state=%b expected 0", PB_state);
        end
        wait_clk(1);
        tests_run++;
        if (PB_state !== 1'b1 || PB_down !== 1'b1 || downs - base_down != 1) begin
            tests_failed++;
            $display("FAIL long_press_258: state=%b down=%b downs=%0d expected 1 1 1",
                     PB_state, PB_down, downs - base_down);
        end
        wait_clk(20);
        PushButton = 1'b0;
        wait_clk(25);
        PushButton = 1'b1;
        wait_clk(300);
        tests_run++;
        if (PB_state !== 1'b1 || ups != base_up) begin
            tests_failed++;
            $display("FAIL short_low_pulse: state=%b ups=%0d expected 1 0", PB_state, ups - base_up);
        end
    endtask

    task automatic test_back_to_back;
        int base_down = downs;
        int base_up   = ups;
        int base_ovl  = overlap;
        int base_wide = wide;
        PushButton = 1'b0;
        wait_clk(400);
        tests_run++;
        if (PB_state !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first_release: state=%b expected 0", PB_state);
        end
        PushButton = 1'b1;
        wait_clk(600);
        PushButton = 1'b0;
        wait_clk(400);
        PushButton = 1'b1;
        wait_clk(1500);
        tests_run++;
        if (PB_state !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second_press: state=%b expected 1", PB_state);
        end
        PushButton = 1'b0;
        wait_clk(400);
        tests_run++;
        if (downs - base_down != 2 || ups - base_up != 3) begin
            tests_failed++;
            $display("FAIL b2b_strobe_counts: downs=%0d ups=%0d expected 2 3", downs - base_down, ups - base_up);
        end
        tests_run++;
        if (overlap != base_ovl || wide != base_wide) begin
            tests_failed++;
            $display("FAIL b2b_strobe_shape: overlap=%0d wide=%0d expected 0 0",
                     overlap - base_ovl, wide - base_wide);
        end
    endtask

    task automatic test_reset_mid_count;
        int base_down;
        PushButton = 1'b1;
        wait_clk(258);
        tests_run++;
        if (PB_state !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_setup_press: state=%b expected 1", PB_state);
        end
        PushButton = 1'b0;
        wait_clk(102);
        tests_run++;
        if (dut.cnt !== 8'd100 || PB_state !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_count_value: cnt=%0d state=%b expected 100 1", dut.cnt, PB_state);
        end
        #3 clr = 1'b0;
        #1;
        tests_run++;
        if (PB_state !== 1'b0 || dut.cnt !== '0 || {PB_down, PB_up} !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_async_clear: state=%b cnt=%0d down/up=%b expected 0 0 00",
                     PB_state, dut.cnt, {PB_down, PB_up});
        end
        PushButton = 1'b1;
        wait_clk(5);
        base_down = downs;
        clr = 1'b1;
        wait_clk(257);
        tests_run++;
        if (PB_state !== 1'b0 || downs != base_down) begin
            tests_failed++;
            $display("FAIL post_reset_257: state=%b downs=%0d expected 0 0", PB_state, downs - base_down);
        end
        wait_clk(1);
        tests_run++;
        if (PB_state !== 1'b1 || PB_down !== 1'b1 || downs - base_down != 1) begin
            tests_failed++;
            $display("FAIL post_reset_258: state=%b down=%b downs=%0d expected 1 1 1",
                     PB_state, PB_down, downs - base_down);
        end
    endtask

    task automatic test_bounce;
        int base_down;
        int base_up;
        int peak = 0;
        PushButton = 1'b0;
        wait_clk(300);
        base_down = downs;
        base_up   = ups;
        for (int i = 0; i < 50; i++) begin
            PushButton = 1'b1;
            run_track(10, peak);
            PushButton = 1'b0;
            run_track(10, peak);
        end
        run_track(300, peak);
        tests_run++;
        if (PB_state !== 1'b0 || downs != base_down || ups != base_up) begin
            tests_failed++;
            $display("FAIL bounce_reject: state=%b downs=%0d ups=%0d expected 0 0 0",
                     PB_state, downs - base_down, ups - base_up);
        end
        tests_run++;
        if (peak != 10) begin
            tests_failed++;
            $display("FAIL bounce_peak: peak cnt=%0d expected 10", peak);
        end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_glitch_low();
        test_short_pulses();
        test_back_to_back();
        test_reset_mid_count();
        test_bounce();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
